// File: rtl/ram_port_arbiter.sv
// Arbiter and sequencer for the shared block RAM data port: serializes CPU and
// AUX req/ack accesses and runs a full-RAM clear sweep on command.
module ram_port_arbiter #(
    parameter int AW    = 12,
    parameter int DW    = 16,
    parameter int DEPTH = 4096
) (
    input  logic          clk,
    input  logic          res,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          aux_req,
    input  logic          aux_we,
    input  logic [AW-1:0] aux_addr,
    input  logic [DW-1:0] aux_wdata,
    output logic          aux_ack,
    output logic [DW-1:0] aux_rdata,
    input  logic          clr_req,
    output logic          clr_done,
    output logic          busy,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata
);

    typedef enum logic [2:0] {IDLE, ACC, WAIT, ACK, CLEAR, DONE} state_t;

    localparam logic            SEL_CPU  = 1'b0;
    localparam logic            SEL_AUX  = 1'b1;
    localparam int unsigned     LAST_IDX = DEPTH - 1;
    localparam logic [AW:0]     CNT_LAST = LAST_IDX[AW:0];
    localparam logic [AW:0]     CNT_ONE  = {{AW{1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic          sel_q, sel_d;
    logic          last_q, last_d;
    logic          clr_pend_q, clr_pend_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] aux_rdata_q, aux_rdata_d;

    logic          own_we;
    logic [AW-1:0] own_addr;
    logic [DW-1:0] own_wdata;

    // The granted requester holds its inputs stable until ack, so the RAM
    // port is driven straight from them rather than from a captured copy.
    assign own_we    = (sel_q == SEL_AUX) ? aux_we    : cpu_we;
    assign own_addr  = (sel_q == SEL_AUX) ? aux_addr  : cpu_addr;
    assign own_wdata = (sel_q == SEL_AUX) ? aux_wdata : cpu_wdata;

    assign busy      = (state_q != IDLE);
    assign cpu_rdata = cpu_rdata_q;
    assign aux_rdata = aux_rdata_q;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        last_d      = last_q;
        clr_pend_d  = clr_pend_q;
        cnt_d       = cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        aux_rdata_d = aux_rdata_q;
        cpu_ack     = 1'b0;
        aux_ack     = 1'b0;
        clr_done    = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_wdata   = '0;

        // A clear requested mid-access is remembered and honoured at the next IDLE.
        if (clr_req && (state_q inside {ACC, WAIT, ACK})) begin
            clr_pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (clr_pend_q || clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else if (cpu_req && aux_req) begin
                    sel_d   = ~last_q;
                    state_d = ACC;
                end else if (cpu_req) begin
                    sel_d   = SEL_CPU;
                    state_d = ACC;
                end else if (aux_req) begin
                    sel_d   = SEL_AUX;
                    state_d = ACC;
                end
            end
            ACC: begin
                ram_we    = own_we;
                ram_addr  = own_addr;
                ram_wdata = own_wdata;
                last_d    = sel_q;
                state_d   = WAIT;
            end
            WAIT: begin
                if (!own_we) begin
                    if (sel_q == SEL_AUX) begin
                        aux_rdata_d = ram_rdata;
                    end else begin
                        cpu_rdata_d = ram_rdata;
                    end
                end
                state_d = ACK;
            end
            ACK: begin
                cpu_ack = (sel_q == SEL_CPU);
                aux_ack = (sel_q == SEL_AUX);
                state_d = IDLE;
            end
            CLEAR: begin
                ram_we   = 1'b1;
                ram_addr = cnt_q[AW-1:0];
                cnt_d    = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                clr_done   = 1'b1;
                clr_pend_d = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= IDLE;
            sel_q       <= SEL_CPU;
            last_q      <= SEL_AUX;
            clr_pend_q  <= 1'b0;
            cnt_q       <= '0;
            cpu_rdata_q <= '0;
            aux_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            clr_pend_q  <= clr_pend_d;
            cnt_q       <= cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            aux_rdata_q <= aux_rdata_d;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a transaction-level model.
module tb_ram_port_arbiter;

    localparam int AW    = 12;
    localparam int DW    = 16;
    localparam int DEPTH = 4096;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } op_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    logic          clk = 1'b0;
    logic          res = 1'b1;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          aux_req = 1'b0, aux_we = 1'b0;
    logic [AW-1:0] aux_addr = '0;
    logic [DW-1:0] aux_wdata = '0;
    logic          aux_ack;
    logic [DW-1:0] aux_rdata;
    logic          clr_req = 1'b0;
    logic          clr_done, busy;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic [DW-1:0] ram_rdata;

    int tests_run    = 0;
    int tests_failed = 0;

    int            cpu_ack_at, aux_ack_at;
    logic [DW-1:0] cpu_rd_seen, aux_rd_seen;
    logic [63:0]   we_log[$];

    logic [DW-1:0] shadow [DEPTH];
    logic          model_last_aux;
    logic [DW-1:0] model_cpu_rd, model_aux_rd;

    logic [DW-1:0] mem [DEPTH];
    vec_t          vecs [8];

    ram_port_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .res(res),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
        .aux_ack(aux_ack), .aux_rdata(aux_rdata),
        .clr_req(clr_req), .clr_done(clr_done), .busy(busy),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Block RAM with registered read, one cycle of latency.
    always @(posedge clk) begin
        ram_rdata <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    function automatic logic [63:0] weEntry(input int k, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        logic [63:0] e;
        e = '0;
        e[47:32] = k[15:0];
        e[27:16] = addr;
        e[15:0]  = data;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " strobes"}, 64'({cpu_ack, aux_ack, clr_done, busy, ram_we}), 64'(0));
        checkOutput({tag, " ram bus"}, 64'({ram_addr, ram_wdata}), 64'(0));
        checkOutput({tag, " cpu_rdata"}, 64'(cpu_rdata), 64'(0));
        checkOutput({tag, " aux_rdata"}, 64'(aux_rdata), 64'(0));
    endtask

    // Starts at #1 after a posedge with the DUT idle; returns likewise.
    task automatic applyStimulus(input bit use_cpu, input bit use_aux, input op_t c, input op_t a);
        bit drop_c, drop_a, timed_out;
        drop_c = 1'b0; drop_a = 1'b0; timed_out = 1'b1;
        we_log.delete();
        cpu_ack_at = -1; aux_ack_at = -1;
        cpu_rd_seen = '0; aux_rd_seen = '0;
        if (use_cpu) begin
            cpu_we = c.we; cpu_addr = c.addr; cpu_wdata = c.wdata; cpu_req = 1'b1;
        end
        if (use_aux) begin
            aux_we = a.we; aux_addr = a.addr; aux_wdata = a.wdata; aux_req = 1'b1;
        end
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            if (drop_c) cpu_req = 1'b0;
            if (drop_a) aux_req = 1'b0;
            if ((!use_cpu || cpu_ack_at >= 0) && (!use_aux || aux_ack_at >= 0)) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
            if (cpu_ack) begin
                if (cpu_ack_at < 0) cpu_ack_at = k;
                cpu_rd_seen = cpu_rdata;
                drop_c = 1'b1;
            end
            if (aux_ack) begin
                if (aux_ack_at < 0) aux_ack_at = k;
                aux_rd_seen = aux_rdata;
                drop_a = 1'b1;
            end
            if (ram_we) we_log.push_back(weEntry(k, ram_addr, ram_wdata));
        end
        if (timed_out) begin
            @(posedge clk); #1;
            cpu_req = 1'b0;
            aux_req = 1'b0;
        end
    endtask

    task automatic applyReset(input string tag);
        res = 1'b1;
        @(posedge clk); #1;
        res = 1'b0;
        @(negedge clk);
        checkIdleOutputs(tag);
        @(posedge clk); #1;
    endtask

    task automatic runRandomTxn(input int idx);
        int          mode, n, exp_cpu_at, exp_aux_at;
        bit          use_cpu, use_aux;
        bit          order [2];
        op_t         c, a;
        logic [63:0] exp_we[$];
        mode    = $urandom_range(0, 2);
        use_cpu = (mode != 1);
        use_aux = (mode != 0);
        c.we    = 1'($urandom_range(0, 1));
        c.addr  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
        c.wdata = DW'($urandom);
        a.we    = 1'($urandom_range(0, 1));
        a.addr  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
        a.wdata = DW'($urandom);
        applyStimulus(use_cpu, use_aux, c, a);

        // Grants are 4 cycles apart; a tie goes to whoever was not served last.
        exp_cpu_at = -1; exp_aux_at = -1;
        if (use_cpu && use_aux) begin
            order[0] = ~model_last_aux;
            order[1] = model_last_aux;
            n = 2;
        end else begin
            order[0] = use_aux;
            order[1] = 1'b0;
            n = 1;
        end
        for (int i = 0; i < n; i++) begin
            op_t o;
            o = order[i] ? a : c;
            if (order[i]) exp_aux_at = 4 * i + 3;
            else          exp_cpu_at = 4 * i + 3;
            if (o.we) begin
                exp_we.push_back(weEntry(4 * i + 1, o.addr, o.wdata));
                shadow[o.addr] = o.wdata;
            end else if (order[i]) begin
                model_aux_rd = shadow[o.addr];
            end else begin
                model_cpu_rd = shadow[o.addr];
            end
            model_last_aux = order[i];
        end

        checkOutput($sformatf("rnd%0d cpu ack cycle", idx), 64'(cpu_ack_at), 64'(exp_cpu_at));
        checkOutput($sformatf("rnd%0d aux ack cycle", idx), 64'(aux_ack_at), 64'(exp_aux_at));
        if (use_cpu) checkOutput($sformatf("rnd%0d cpu_rdata", idx), 64'(cpu_rd_seen), 64'(model_cpu_rd));
        if (use_aux) checkOutput($sformatf("rnd%0d aux_rdata", idx), 64'(aux_rd_seen), 64'(model_aux_rd));
        checkOutput($sformatf("rnd%0d ram write count", idx), 64'(we_log.size()), 64'(exp_we.size()));
        for (int i = 0; i < exp_we.size() && i < we_log.size(); i++) begin
            checkOutput($sformatf("rnd%0d ram write %0d", idx, i), we_log[i], exp_we[i]);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   ack_who[$], ack_cyc[$];
        bit   drop_c, drop_a, drop;
        int   n_writes, bad_writes, done_cnt, done_at, ack_at, busy_low, first_wr, nonzero, stray;
        logic [DW-1:0] rd;
        op_t  op;

        vecs[0] = '{1'b1, 12'h06E, 16'h00A5, 16'h0000};
        vecs[1] = '{1'b0, 12'h06E, 16'h0000, 16'h00A5};
        vecs[2] = '{1'b1, 12'h000, 16'hFFFF, 16'h00A5};
        vecs[3] = '{1'b1, 12'hFFF, 16'h8001, 16'h00A5};
        vecs[4] = '{1'b0, 12'h000, 16'h0000, 16'hFFFF};
        vecs[5] = '{1'b0, 12'hFFF, 16'h0000, 16'h8001};
        vecs[6] = '{1'b1, 12'h06E, 16'h1234, 16'h8001};
        vecs[7] = '{1'b0, 12'h06E, 16'h0000, 16'h1234};

        repeat (2) @(posedge clk);
        #1;
        res = 1'b0;
        @(negedge clk);
        checkIdleOutputs("reset");
        @(posedge clk); #1;

        // Both requesters held, each dropping for one cycle after its ack.
        cpu_we = 1'b0; aux_we = 1'b0; cpu_addr = 12'h001; aux_addr = 12'h002;
        cpu_req = 1'b1; aux_req = 1'b1;
        drop_c = 1'b0; drop_a = 1'b0;
        for (int cyc = 0; cyc < 80 && ack_who.size() < 8; cyc++) begin
            @(negedge clk);
            if (cpu_ack) begin ack_who.push_back(0); ack_cyc.push_back(cyc); drop_c = 1'b1; end
            if (aux_ack) begin ack_who.push_back(1); ack_cyc.push_back(cyc); drop_a = 1'b1; end
            @(posedge clk); #1;
            cpu_req = !drop_c; aux_req = !drop_a;
            drop_c = 1'b0; drop_a = 1'b0;
        end
        cpu_req = 1'b0; aux_req = 1'b0;
        checkOutput("rr ack count", 64'(ack_who.size()), 64'(8));
        for (int i = 0; i < ack_who.size(); i++) begin
            checkOutput($sformatf("rr grant %0d owner", i), 64'(ack_who[i]), 64'(i % 2));
            if (i == 0) checkOutput("rr first ack cycle", 64'(ack_cyc[0]), 64'(3));
            else checkOutput($sformatf("rr ack spacing %0d", i), 64'(ack_cyc[i] - ack_cyc[i-1]), 64'(4));
        end

        for (int i = 0; i < 8; i++) begin
            op.we = vecs[i].we; op.addr = vecs[i].addr; op.wdata = vecs[i].wdata;
            applyStimulus(1'b1, 1'b0, op, op);
            checkOutput($sformatf("vec%0d cpu ack cycle", i), 64'(cpu_ack_at), 64'(3));
            checkOutput($sformatf("vec%0d aux ack absent", i), 64'(aux_ack_at), 64'(-1));
            checkOutput($sformatf("vec%0d cpu_rdata", i), 64'(cpu_rd_seen), 64'(vecs[i].exp_rdata));
            checkOutput($sformatf("vec%0d ram write count", i), 64'(we_log.size()), 64'(vecs[i].we));
            checkOutput($sformatf("vec%0d ram write", i),
                        (we_log.size() > 0) ? we_log[0] : 64'(0),
                        vecs[i].we ? weEntry(1, vecs[i].addr, vecs[i].wdata) : 64'(0));
        end

        op.we = 1'b1; op.addr = 12'h070; op.wdata = 16'hBEEF;
        applyStimulus(1'b0, 1'b1, op, op);
        checkOutput("aux write ack cycle", 64'(aux_ack_at), 64'(3));

        // Clear and CPU read requested in the same idle cycle.
        clr_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h070; cpu_req = 1'b1;
        n_writes = 0; bad_writes = 0; done_cnt = 0; done_at = -1; ack_at = -1; busy_low = 0;
        drop = 1'b0; rd = '1;
        for (int k = 1; k <= 4200; k++) begin
            @(posedge clk); #1;
            clr_req = 1'b0;
            if (drop) break;
            @(negedge clk);
            if (ram_we) begin
                if (ram_addr != AW'(n_writes) || ram_wdata != '0 || k != n_writes + 1) bad_writes++;
                n_writes++;
            end
            if (!busy && k <= 4097) busy_low++;
            if (clr_done) begin done_cnt++; done_at = k; end
            if (cpu_ack) begin ack_at = k; rd = cpu_rdata; drop = 1'b1; end
        end
        cpu_req = 1'b0;
        checkOutput("clear write count", 64'(n_writes), 64'(DEPTH));
        checkOutput("clear bad writes", 64'(bad_writes), 64'(0));
        checkOutput("clear done pulses", 64'(done_cnt), 64'(1));
        checkOutput("clear done cycle", 64'(done_at), 64'(DEPTH + 1));
        checkOutput("clear busy gaps", 64'(busy_low), 64'(0));
        checkOutput("post-clear cpu ack cycle", 64'(ack_at), 64'(DEPTH + 5));
        checkOutput("post-clear cpu_rdata", 64'(rd), 64'(0));
        nonzero = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== '0) nonzero++;
        checkOutput("ram words left nonzero", 64'(nonzero), 64'(0));

        // One-cycle clear pulse while the AUX access is in ACC.
        aux_we = 1'b0; aux_addr = 12'h070; aux_req = 1'b1;
        first_wr = -1; done_at = -1; ack_at = -1; drop = 1'b0; rd = '1;
        for (int k = 1; k <= 4200; k++) begin
            @(posedge clk); #1;
            clr_req = (k == 1);
            if (drop) aux_req = 1'b0;
            if (done_at >= 0) break;
            @(negedge clk);
            if (aux_ack) begin ack_at = k; rd = aux_rdata; drop = 1'b1; end
            if (ram_we && first_wr < 0) first_wr = k;
            if (clr_done) done_at = k;
        end
        aux_req = 1'b0; clr_req = 1'b0;
        checkOutput("pend aux ack cycle", 64'(ack_at), 64'(3));
        checkOutput("pend aux_rdata", 64'(rd), 64'(0));
        checkOutput("pend first clear write", 64'(first_wr), 64'(5));
        checkOutput("pend clear done cycle", 64'(done_at), 64'(DEPTH + 5));

        applyReset("reset before random");
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
        model_last_aux = 1'b1;
        model_cpu_rd = '0;
        model_aux_rd = '0;
        for (int i = 0; i < 40; i++) runRandomTxn(i);

        op.we = 1'b1; op.addr = 12'h300; op.wdata = 16'h1234;
        applyStimulus(1'b1, 1'b0, op, op);
        op.we = 1'b0;
        applyStimulus(1'b1, 1'b0, op, op);
        checkOutput("pre-reset cpu_rdata", 64'(cpu_rd_seen), 64'(16'h1234));
        op.we = 1'b1; op.addr = 12'd200; op.wdata = 16'h5A5A;
        applyStimulus(1'b1, 1'b0, op, op);
        checkOutput("addr 200 write ack cycle", 64'(cpu_ack_at), 64'(3));

        // Reset lands while the sweep is writing word 100.
        clr_req = 1'b1;
        for (int k = 1; k <= 101; k++) begin
            @(posedge clk); #1;
            clr_req = 1'b0;
            @(negedge clk);
        end
        checkOutput("sweep at word 100", 64'({ram_we, ram_addr}), 64'({1'b1, 12'd100}));
        res = 1'b1;
        @(posedge clk); #1;
        res = 1'b0;
        @(negedge clk);
        checkIdleOutputs("reset mid-clear");
        stray = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (clr_done || busy) stray++;
        end
        checkOutput("aborted clear activity", 64'(stray), 64'(0));
        @(posedge clk); #1;
        op.we = 1'b0; op.addr = 12'd200;
        applyStimulus(1'b1, 1'b0, op, op);
        checkOutput("addr 200 ack cycle", 64'(cpu_ack_at), 64'(3));
        checkOutput("addr 200 survives abort", 64'(cpu_rd_seen), 64'(16'h5A5A));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Arbiter and sequencer for the shared 4096x16 block RAM data port (port B). It serializes accesses from two requesters, the CPU bus and an auxiliary writer/reader such as an IR code logger or DMA. It also runs a hardware RAM-clear sweep on command. The block drives the RAM port directly; requesters see a req/ack handshake with registered read data.

## Interface
Parameters:
- AW, 12, RAM address width
- DW, 16, RAM data width
- DEPTH, 4096, words swept by clear (must equal 2**AW)

Ports:
- clk  in  1  system clock; single clock domain
- res  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
- cpu_addr  in  AW  CPU word address; stable while cpu_req
- cpu_wdata  in  DW  CPU write data; stable while cpu_req
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DW  read data; valid when cpu_ack, held until next CPU read completes
- aux_req, aux_we, aux_addr, aux_wdata, aux_ack, aux_rdata  (same directions, widths and meaning as the cpu_* set)
- clr_req  in  1  request full-RAM clear; level, sampled each cycle
- clr_done  out  1  one-cycle pulse when the sweep finishes
- busy  out  1  high while the FSM is not IDLE; also gates CPU clock upstream during clear
- ram_addr  out  AW  RAM port address
- ram_wdata  out  DW  RAM port write data
- ram_we  out  1  RAM port write enable
- ram_rdata  in  DW  RAM port registered read data; 1-cycle latency after address

## Operation
- FSM states: IDLE, ACC, WAIT, ACK, CLEAR, DONE. A `sel` register records the owner (CPU/AUX) for ACC/WAIT/ACK.
- IDLE priority:
  - clr_pend or clr_req → CLEAR, with counter = 0.
  - Else exactly one of cpu_req/aux_req set → ACC for that requester.
  - Else both set → round-robin: grant the requester not granted last. `last` resets to AUX, so the CPU wins the first tie.
  - Else stay in IDLE.
- ACC (1 cycle):
  - ram_addr = owner addr; ram_wdata = owner wdata; ram_we = owner we. All combinational from the held requester inputs.
  - Update `last` = owner. → WAIT.
- WAIT (1 cycle): ram_rdata is valid. If owner we = 0, capture it into the owner's rdata register at the end of the cycle. → ACK.
- ACK (1 cycle): owner ack = 1. → IDLE.
- The requester must deassert or change req in the cycle after ack. IDLE re-samples req then.
- CLEAR: ram_we = 1, ram_wdata = 0, ram_addr = counter.
  - counter increments each cycle.
  - On counter = DEPTH-1, that word is written, then → DONE.
- DONE (1 cycle): clr_done = 1, clr_pend cleared. → IDLE.
- clr_pend: set when clr_req = 1 in any state other than IDLE, CLEAR and DONE. clr_req during CLEAR/DONE is ignored.
- Outside ACC/CLEAR: ram_we = 0, ram_addr = 0, ram_wdata = 0.
- rdata registers are never changed by writes or by the clear.
- Counter width is AW+1; no wrap occurs because the exit happens at DEPTH-1.

## Timing
- Request sampled in IDLE at cycle G:
  - RAM driven at G+1.
  - Read data captured at the end of G+2.
  - ack at G+3.
  - Next grant earliest at G+4.
- The same 4-cycle latency applies to reads and writes. Maximum throughput is 1 access per 4 cycles.
- Clear sampled at cycle C: writes occupy C+1 .. C+DEPTH, clr_done at C+DEPTH+1, IDLE at C+DEPTH+2.
- busy = 0 only in IDLE.
- Requests arriving during CLEAR wait, no ack, and are served after DONE with round-robin state unchanged.
- res = 1 at any edge: next cycle is IDLE.
  - counter = 0, clr_pend = 0, last = AUX.
  - All outputs 0, including cpu_rdata and aux_rdata.
  - An in-flight access is dropped with no ack; any clear is aborted with no clr_done.

## Test plan
- CPU write 0x00A5 to 0x06E, then CPU read 0x06E → ram_we high only at G+1 with addr 0x06E; read cpu_ack at G+3 with cpu_rdata = 0x00A5; aux_ack stays 0.
- cpu_req and aux_req both held continuously, each dropping for one cycle after its ack → grants alternate CPU, AUX, CPU, AUX; 4 cycles per grant, acks 4 cycles apart.
- clr_req and cpu_req in the same IDLE cycle → 4096 writes of 0x0000 to addrs 0..4095; clr_done once; then the CPU access completes and a read of 0x0070 returns 0x0000.
- clr_req pulsed for 1 cycle during an AUX ACC → AUX ack at the normal time, then CLEAR starts from the next IDLE without clr_req reasserted.
- res asserted mid-clear at counter = 100 → next cycle ram_we = 0, busy = 0, no clr_done; a subsequent CPU read of address 200 returns the pre-clear value.
- Reset release with cpu_rdata previously 0x1234 → cpu_rdata = 0 and all acks 0 in the first post-reset cycle.
